// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types and framing constants for the UART transceiver
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter, reloads while stopped and on every wrap
module uart_bit_timer #(
  parameter int CLK_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick,
  output logic half_tick
);
  localparam int W = $clog2(CLK_PER_BIT);
  localparam logic [W-1:0] TOP = W'(CLK_PER_BIT - 1);
  localparam logic [W-1:0] MID = W'(CLK_PER_BIT - CLK_PER_BIT / 2);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst || !run || cnt == '0) cnt <= TOP;
    else cnt <= cnt - 1'b1;
  // half_tick lands CLK_PER_BIT/2 cycles into each running period
  assign bit_tick  = cnt == '0;
  assign half_tick = cnt == MID;
endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: 8N1 UART TX/RX pair; define UART_FRAME_ERR_EN to add the rx_frame_err pulse
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done
`ifdef UART_FRAME_ERR_EN
  ,
  output logic       rx_frame_err
`endif
);
  tx_state_t tx_state;
  rx_state_t rx_state;
  logic [DATA_BITS-1:0] tx_sh, rx_sh;
  logic [2:0] tx_cnt, rx_cnt;
  logic tx_tick, tx_half_unused, rx_half, rx_bit_unused;
  logic rx_s1, rx_s2;
  uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx_timer (
    .clk(clk), .rst(rst), .run(tx_state != TX_IDLE),
    .bit_tick(tx_tick), .half_tick(tx_half_unused)
  );
  uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx_timer (
    .clk(clk), .rst(rst), .run(rx_state != RX_IDLE),
    .bit_tick(rx_bit_unused), .half_tick(rx_half)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx       <= IDLE_LEVEL;
      tx_busy  <= 1'b0;
      tx_sh    <= '0;
      tx_cnt   <= '0;
    end else
      case (tx_state)
        TX_IDLE:
          if (tx_start) begin
            tx_state <= TX_START;
            tx_sh    <= tx_data;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
          end
        TX_START:
          if (tx_tick) begin
            tx_state <= TX_DATA;
            tx       <= tx_sh[0];
          end
        TX_DATA:
          if (tx_tick) begin
            tx_sh  <= tx_sh >> 1;
            tx_cnt <= tx_cnt + 3'd1;
            tx     <= tx_cnt == 3'(DATA_BITS - 1) ? IDLE_LEVEL : tx_sh[1];
            if (tx_cnt == 3'(DATA_BITS - 1)) tx_state <= TX_STOP;
          end
        TX_STOP:
          if (tx_tick) begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
          end
      endcase
  // every receive decision looks only at the synchronised rx_s2
  always_ff @(posedge clk)
    if (!rst) begin
      rx_s1    <= IDLE_LEVEL;
      rx_s2    <= IDLE_LEVEL;
      rx_state <= RX_IDLE;
      rx_sh    <= '0;
      rx_cnt   <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_done <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: if (rx_s2 != IDLE_LEVEL) rx_state <= RX_START;
        RX_START: if (rx_half) rx_state <= rx_s2 == IDLE_LEVEL ? RX_IDLE : RX_DATA;
        RX_DATA:
          if (rx_half) begin
            rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            rx_cnt <= rx_cnt + 3'd1;
            if (rx_cnt == 3'(DATA_BITS - 1)) rx_state <= RX_STOP;
          end
        RX_STOP:
          if (rx_half) begin
            rx_state <= RX_IDLE;
            rx_done  <= rx_s2 == IDLE_LEVEL;
            if (rx_s2 == IDLE_LEVEL) rx_data <= rx_sh;
`ifdef UART_FRAME_ERR_EN
            rx_frame_err <= rx_s2 != IDLE_LEVEL;
`endif
          end
      endcase
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: loopback and directly-driven frames checked against a frame-level model
module tb_uart_transceiver;
  localparam int CPB = 87;
  logic clk = 1'b0, rst = 1'b0, tx_start = 1'b0, loop = 1'b1, rx_drv = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx, tx_busy, rx_line, rx_done;
  logic [7:0] rx_data;
  logic [7:0] got_q[$], exp_q[$];
  int checks = 0, errors = 0, fe_cnt = 0;
`ifdef UART_FRAME_ERR_EN
  logic rx_frame_err;
`endif
  assign rx_line = loop ? tx : rx_drv;
  always #50 clk = ~clk;
  uart_transceiver #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx), .tx_busy(tx_busy), .rx(rx_line), .rx_data(rx_data), .rx_done(rx_done)
`ifdef UART_FRAME_ERR_EN
    , .rx_frame_err(rx_frame_err)
`endif
  );
  always @(negedge clk) begin
    if (rx_done) got_q.push_back(rx_data);
`ifdef UART_FRAME_ERR_EN
    if (rx_frame_err) fe_cnt++;
`endif
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // called at a negedge while idle; returns at the negedge of the cycle tx_busy falls
  task automatic send(input logic [7:0] d, input bit poke);
    logic [9:0] fb;
    int busy_len;
    fb = {1'b1, d, 1'b0};
    busy_len = 0;
    chk("tx_idle_before_start", tx_busy, 0);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data = 8'($urandom);
    for (int j = 0; j < 10 * CPB; j++) begin
      if (tx_busy) busy_len++;
      if (j == 0) chk("tx_start_bit_first_cycle", tx, 0);
      if (j % CPB == CPB / 2) chk($sformatf("tx_bit%0d", j / CPB), tx, fb[j / CPB]);
      tx_start = poke && j == 4 * CPB;
      if (tx_start) tx_data = 8'h3C;
      @(negedge clk);
    end
    tx_start = 1'b0;
    chk("tx_busy_fall", tx_busy, 0);
    chk("tx_busy_len", busy_len, 10 * CPB);
    exp_q.push_back(d);
  endtask
  task automatic drive_frame(input logic [7:0] d, input bit stop, input int per);
    logic [9:0] fb;
    fb = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fb[i];
      repeat (per) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (stop) exp_q.push_back(d);
  endtask
  initial begin
    logic [7:0] b;
    int n;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_tx_busy", tx_busy, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_done", rx_done, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send(8'hA5, 0);
    chk("a5_count", got_q.size(), 1);
    chk("a5_rx_data", rx_data, 8'hA5);
    send(8'h00, 0);
    send(8'hFF, 0);
    chk("b2b_count", got_q.size(), 3);
    send(8'($urandom), 1);
    repeat (2 * CPB) @(negedge clk);
    chk("busy_poke_count", got_q.size(), 4);
    chk("busy_poke_tx_idle", {tx, tx_busy}, 2'b10);
    repeat (4) begin
      send(8'($urandom), 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    chk("random_count", got_q.size(), 8);
    loop = 1'b0;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_no_done", got_q.size(), 8);
    drive_frame(8'h5A, 1, CPB);
    chk("after_glitch_rx_data", rx_data, 8'h5A);
    drive_frame(8'($urandom), 1, CPB - 3);
    drive_frame(8'($urandom), 1, CPB + 3);
    chk("skew_count", got_q.size(), 11);
    b = rx_data;
    drive_frame(8'h81, 0, CPB);
    chk("frame_err_no_done", got_q.size(), 11);
    chk("frame_err_rx_data_held", rx_data, b);
`ifdef UART_FRAME_ERR_EN
    chk("frame_err_pulses", fe_cnt, 1);
`endif
    loop = 1'b1;
    n = got_q.size();
    tx_data = 8'($urandom);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_tx", tx, 1);
    chk("midreset_tx_busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    chk("midreset_no_done", got_q.size(), n);
    chk("midreset_still_idle", tx_busy, 0);
    chk("total_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rx_byte%0d", i), got_q[i], exp_q[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Single-clock 8N1 UART transmitter and receiver pair used as the serial front end of the UART–SPI bridge. The TX half serialises a byte on a one-cycle start request. The RX half recovers bytes from an asynchronous serial line and pulses a done strobe. Both halves share one bit-period parameter, and the block is loopback-testable by tying `tx` to `rx`.

## Interface
- `CLK_PER_BIT`, default 87: clock cycles per serial bit, ≥ 4. For example, 10 MHz / 87 ≈ 115200 baud.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `tx_start`  in  1  one-cycle request to send `tx_data`; honoured only while `tx_busy` is 0.
- `tx_data`  in  8  byte to transmit; captured in the cycle `tx_start` is accepted.
- `tx`  out  1  serial output; idle high.
- `tx_busy`  out  1  high from the cycle after acceptance until the stop bit completes.
- `rx`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  8  last correctly framed byte; held until the next one.
- `rx_done`  out  1  one-cycle pulse when `rx_data` updates.
- `rx_frame_err`  out  1  present only with `UART_FRAME_ERR_EN`; see Configuration.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM states: IDLE → START → DATA(8 bits) → STOP → IDLE.
  - In IDLE, `tx_start`=1 latches `tx_data` into a shift register and enters START.
  - Each state lasts exactly `CLK_PER_BIT` cycles, counted by a bit timer.
  - `tx_start` while busy is ignored; there is no queueing.
- RX input: `rx` passes through a 2-flop synchroniser. Every RX decision uses the synchronised signal.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - In IDLE, a synchronised low level starts the bit timer.
  - At `CLK_PER_BIT/2` (integer division), the start bit is re-sampled. If it is high, the event is a glitch and the FSM returns to IDLE.
  - Each data bit is sampled at mid-bit, every `CLK_PER_BIT` cycles thereafter, and shifted in LSB first.
  - The stop bit is sampled at mid-bit. If it is 1, `rx_data` is loaded and `rx_done` pulses. If it is 0, the byte is discarded and there is no done pulse.
  - After the stop-bit sample, the FSM returns to IDLE immediately, so back-to-back frames are accepted.
- Reset values: `tx`=1, `tx_busy`=0, `rx_data`=8'h00, `rx_done`=0, `rx_frame_err`=0. Both FSMs go to IDLE and all counters to 0.
- Reset asserted mid-frame aborts the frame. `tx` returns high on the next edge and no partial byte is delivered.

## Timing
- TX, with `tx_start` sampled high in cycle k while idle:
  - `tx` low and `tx_busy` high from k+1.
  - Data bit i occupies cycles k+1+(i+1)·CPB through k+(i+2)·CPB.
  - Stop bit starts at k+1+9·CPB.
  - `tx_busy` falls at k+1+10·CPB. A new `tx_start` is accepted in that same cycle.
- The TX output is registered, with no combinational path from inputs to `tx`.
- RX: `rx_done` asserts 1 cycle after the stop-bit mid-sample. This is about 9.5·CPB + 3 cycles after the `rx` falling edge.
- RX tolerates about ±4% baud mismatch.
- `rx_done` is exactly 1 cycle wide. `rx_data` is valid in the same cycle `rx_done` is high.

## Configuration
- `UART_FRAME_ERR_EN` defined:
  - Adds the `rx_frame_err` output.
  - It is a one-cycle pulse when the stop bit is sampled 0, timed like `rx_done`.
  - `rx_data` is not updated on a framing error.
- `UART_FRAME_ERR_EN` undefined: the port is absent, and bad frames are silently dropped.

## Structure
- Shared package `uart_pkg` holds:
  - state typedefs `tx_state_t` and `rx_state_t`;
  - `DATA_BITS` = 8;
  - `IDLE_LEVEL` = 1'b1.
- One natural sub-module: `uart_bit_timer`. It is a parameterised down-counter with a reload, producing `bit_tick` and `half_tick` strobes. It is instantiated once in TX and once in RX.
- The TX and RX FSMs live in the top level.

## Test plan
- Loopback `tx`→`rx`, CPB=87, 10 MHz:
  - Stimulus: reset released, then `tx_start` pulsed with `tx_data`=8'hA5.
  - Response: `rx_done` pulses once, `rx_data`=8'hA5, `tx_busy` high for exactly 870 cycles.
- Back-to-back sends of 8'h00 then 8'hFF, the second `tx_start` in the cycle `tx_busy` falls → two `rx_done` pulses with 8'h00 then 8'hFF.
- `tx_start` asserted while `tx_busy`=1 with 8'h3C → ignored; only the first byte is received.
- 20-cycle low glitch on `rx` → no `rx_done`; the FSM is back in IDLE and the next valid frame of 8'h5A is received.
- Frame 8'h81 with the stop bit forced low → no `rx_done` and `rx_data` unchanged; `rx_frame_err` pulses when `UART_FRAME_ERR_EN` is defined.
- `rst`=0 asserted in the middle of data bit 3 → `tx`=1 and `tx_busy`=0 on the next edge; no `rx_done`.
